// File: rtl/aes_pkg.sv
// Shared definitions for the AES CTR controller slice.
//   BLOK_W     : AES block width in bits.
//   blok_t     : one 128-bit block (counter block, keystream, text).
//   durum_t    : controller state encoding.
//   blok_xor   : keystream/plaintext combine helper.
package aes_pkg;

    localparam int BLOK_W = 128;

    typedef logic [BLOK_W-1:0] blok_t;

    typedef enum logic [1:0] {
        BOS     = 2'd0,
        CALIS   = 2'd1,
        TUKENDI = 2'd2
    } durum_t;

    function automatic blok_t blok_xor(input blok_t a, input blok_t b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/aes_fifo.sv
// Synchronous FIFO used for both the plaintext and ciphertext buffers.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_veri   : write strobe and data (ignored when full)
//   pop               : read strobe (ignored when empty)
//   bas_veri          : head of queue, forced to zero while empty
//   full, empty       : occupancy flags
module aes_fifo
    import aes_pkg::*;
#(
    parameter int DERINLIK = 16,
    parameter int W        = BLOK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_veri,
    input  logic         pop,
    output logic [W-1:0] bas_veri,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0] PTR_BIR = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DERINLIK];
    logic         push_ok_s;
    logic         pop_ok_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign bas_veri  = empty ? {W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_BIR;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_BIR;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_veri;
        end
    end

endmodule

// File: rtl/aes_ctr_kontrol.sv
// CTR-mode controller around aes_engine. Issues {prefix, counter} blocks,
// buffers plaintext while blocks are in flight, XORs the returned keystream
// with the paired plaintext and presents ciphertext on a ready/valid output.
// A credit counter bounds in-flight + buffered ciphertext to DERINLIK so the
// engine (which has no backpressure) can never overflow the output FIFO.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   baslat, nonce            : reload prefix (nonce[127:SAYAC_W]) and clear counter
//   acik_metin, a_gecerli, a_hazir         : plaintext input handshake
//   motor_blok, motor_g_gecerli, motor_hazir : engine request side
//   motor_sifre, motor_c_gecerli           : engine keystream return
//   sifreli_metin, s_gecerli, s_hazir      : ciphertext output handshake
//   tukendi                  : counter exhausted, sticky until baslat
// Optional build macro AES_CTR_ISTATISTIK_EN adds blok_sayisi[31:0], a
// saturating count of ciphertext pops cleared by baslat.
module aes_ctr_kontrol
    import aes_pkg::*;
#(
    parameter int DERINLIK = 16,
    parameter int SAYAC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baslat,
    input  logic [BLOK_W-1:0] nonce,
    input  logic [BLOK_W-1:0] acik_metin,
    input  logic              a_gecerli,
    output logic              a_hazir,
    output logic [BLOK_W-1:0] motor_blok,
    output logic              motor_g_gecerli,
    input  logic              motor_hazir,
    input  logic [BLOK_W-1:0] motor_sifre,
    input  logic              motor_c_gecerli,
    output logic [BLOK_W-1:0] sifreli_metin,
    output logic              s_gecerli,
    input  logic              s_hazir,
    output logic              tukendi
`ifdef AES_CTR_ISTATISTIK_EN
    ,
    output logic [31:0]       blok_sayisi
`endif
);

    localparam int KREDI_W = $clog2(DERINLIK) + 1;
    localparam int ONEK_W  = BLOK_W - SAYAC_W;

    localparam logic [KREDI_W-1:0] KREDI_DOLU  = KREDI_W'(DERINLIK);
    localparam logic [KREDI_W-1:0] KREDI_BIR   = {{(KREDI_W-1){1'b0}}, 1'b1};
    localparam logic [KREDI_W-1:0] KREDI_SIFIR = {KREDI_W{1'b0}};
    localparam logic [SAYAC_W-1:0] SAYAC_MAX   = {SAYAC_W{1'b1}};
    localparam logic [SAYAC_W-1:0] SAYAC_BIR   = {{(SAYAC_W-1){1'b0}}, 1'b1};

    durum_t              durum_r;
    durum_t              durum_s;
    logic                a_hazir_s;
    logic                gonder_s;
    logic [ONEK_W-1:0]   onek_r;
    logic [SAYAC_W-1:0]  sayac_r;
    logic [KREDI_W-1:0]  kredi_r;

    logic                pt_bos_s;
    logic                pt_dolu_s;
    logic [BLOK_W-1:0]   pt_bas_s;
    logic                ct_bos_s;
    logic                ct_dolu_s;
    logic                donus_s;
    logic                cikis_pop_s;
    logic                unused_s;

    assign a_hazir     = a_hazir_s;
    assign tukendi     = (durum_r == TUKENDI);
    assign s_gecerli   = !ct_bos_s;
    assign cikis_pop_s = !ct_bos_s && s_hazir;
    // A keystream beat with no paired plaintext is a protocol error and is dropped.
    assign donus_s     = motor_c_gecerli && !pt_bos_s;

    // Low nonce bits are overwritten by the counter; FIFO full flags are
    // unreachable because the credit counter bounds both occupancies.
    assign unused_s = ^{nonce[SAYAC_W-1:0], pt_dolu_s, ct_dolu_s};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum_r <= BOS;
        end else begin
            durum_r <= durum_s;
        end
    end

    // Next-state and input-ready decode.
    always_comb begin
        durum_s   = durum_r;
        a_hazir_s = 1'b0;
        gonder_s  = 1'b0;
        case (durum_r)
            BOS: begin
                if (baslat) begin
                    durum_s = CALIS;
                end else begin
                    durum_s = BOS;
                end
            end
            CALIS: begin
                a_hazir_s = motor_hazir && (kredi_r != KREDI_SIFIR);
                gonder_s  = a_gecerli && a_hazir_s;
                // baslat reloads the counter, so it overrides exhaustion.
                if (baslat) begin
                    durum_s = CALIS;
                end else if (gonder_s && (sayac_r == SAYAC_MAX)) begin
                    durum_s = TUKENDI;
                end else begin
                    durum_s = CALIS;
                end
            end
            TUKENDI: begin
                if (baslat) begin
                    durum_s = CALIS;
                end else begin
                    durum_s = TUKENDI;
                end
            end
            default: begin
                durum_s = BOS;
            end
        endcase
    end

    // Prefix and counter; an issue in the same cycle as baslat still uses
    // the old values because motor_blok samples them before the reload lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            onek_r  <= {ONEK_W{1'b0}};
            sayac_r <= {SAYAC_W{1'b0}};
        end else if (baslat) begin
            onek_r  <= nonce[BLOK_W-1:SAYAC_W];
            sayac_r <= {SAYAC_W{1'b0}};
        end else if (gonder_s && (sayac_r != SAYAC_MAX)) begin
            sayac_r <= sayac_r + SAYAC_BIR;
        end
    end

    // Registered engine request, valid only in the cycle after an issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            motor_g_gecerli <= 1'b0;
            motor_blok      <= {BLOK_W{1'b0}};
        end else begin
            motor_g_gecerli <= gonder_s;
            if (gonder_s) begin
                motor_blok <= {onek_r, sayac_r};
            end
        end
    end

    // Credit = free slots across in-flight blocks and buffered ciphertext.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kredi_r <= KREDI_DOLU;
        end else if (gonder_s && !cikis_pop_s) begin
            kredi_r <= kredi_r - KREDI_BIR;
        end else if (!gonder_s && cikis_pop_s) begin
            kredi_r <= kredi_r + KREDI_BIR;
        end
    end

    aes_fifo #(
        .DERINLIK (DERINLIK),
        .W        (BLOK_W)
    ) u_pt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gonder_s),
        .push_veri (acik_metin),
        .pop       (donus_s),
        .bas_veri  (pt_bas_s),
        .full      (pt_dolu_s),
        .empty     (pt_bos_s)
    );

    aes_fifo #(
        .DERINLIK (DERINLIK),
        .W        (BLOK_W)
    ) u_ct_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (donus_s),
        .push_veri (blok_xor(pt_bas_s, motor_sifre)),
        .pop       (cikis_pop_s),
        .bas_veri  (sifreli_metin),
        .full      (ct_dolu_s),
        .empty     (ct_bos_s)
    );

`ifdef AES_CTR_ISTATISTIK_EN
    logic [31:0] blok_sayisi_r;

    // Saturating count of ciphertext pops since reset or the last baslat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blok_sayisi_r <= 32'd0;
        end else if (baslat) begin
            blok_sayisi_r <= 32'd0;
        end else if (cikis_pop_s && (blok_sayisi_r != 32'hFFFF_FFFF)) begin
            blok_sayisi_r <= blok_sayisi_r + 32'd1;
        end
    end

    assign blok_sayisi = blok_sayisi_r;
`else
    // Statistics counter not built; no extra port.
`endif

endmodule

// File: tb/tb_aes_ctr_kontrol.sv
module tb_aes_ctr_kontrol;

    logic         clk;
    logic         rst;
    int           n_chk  = 0;
    int           n_fail = 0;

    // Main DUT (SAYAC_W = 32)
    logic         baslat, a_gecerli, a_hazir, motor_g_gecerli, motor_hazir;
    logic         motor_c_gecerli, s_gecerli, s_hazir, tukendi;
    logic [127:0] nonce, acik_metin, motor_blok, motor_sifre, sifreli_metin;
`ifdef AES_CTR_ISTATISTIK_EN
    logic [31:0]  blok_sayisi, blok_sayisi8;
`endif

    // Second DUT (SAYAC_W = 8) for counter exhaustion
    logic         baslat8, a_gecerli8, a_hazir8, motor_g_gecerli8, motor_hazir8;
    logic         motor_c_gecerli8, s_gecerli8, s_hazir8, tukendi8;
    logic [127:0] nonce8, acik_metin8, motor_blok8, motor_sifre8, sifreli_metin8;

    aes_ctr_kontrol #(.DERINLIK(16), .SAYAC_W(32)) u_dut (
        .clk(clk), .rst(rst), .baslat(baslat), .nonce(nonce),
        .acik_metin(acik_metin), .a_gecerli(a_gecerli), .a_hazir(a_hazir),
        .motor_blok(motor_blok), .motor_g_gecerli(motor_g_gecerli),
        .motor_hazir(motor_hazir), .motor_sifre(motor_sifre),
        .motor_c_gecerli(motor_c_gecerli), .sifreli_metin(sifreli_metin),
        .s_gecerli(s_gecerli), .s_hazir(s_hazir), .tukendi(tukendi)
`ifdef AES_CTR_ISTATISTIK_EN
        , .blok_sayisi(blok_sayisi)
`endif
    );

    aes_ctr_kontrol #(.DERINLIK(16), .SAYAC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .baslat(baslat8), .nonce(nonce8),
        .acik_metin(acik_metin8), .a_gecerli(a_gecerli8), .a_hazir(a_hazir8),
        .motor_blok(motor_blok8), .motor_g_gecerli(motor_g_gecerli8),
        .motor_hazir(motor_hazir8), .motor_sifre(motor_sifre8),
        .motor_c_gecerli(motor_c_gecerli8), .sifreli_metin(sifreli_metin8),
        .s_gecerli(s_gecerli8), .s_hazir(s_hazir8), .tukendi(tukendi8)
`ifdef AES_CTR_ISTATISTIK_EN
        , .blok_sayisi(blok_sayisi8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in keystream generator: any fixed bijection of the counter block.
    function automatic logic [127:0] ks(input logic [127:0] b);
        return {b[100:0], b[127:101]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Engine model, 3-cycle in-order pipeline, not reset with the DUT.
    logic [2:0]   e_v = 3'b000;
    logic [127:0] e_d0 = 128'h0, e_d1 = 128'h0, e_d2 = 128'h0;
    logic         spur = 1'b0;
    always @(posedge clk) begin
        e_v  <= {e_v[1:0], motor_g_gecerli};
        e_d0 <= ks(motor_blok);
        e_d1 <= e_d0;
        e_d2 <= e_d1;
    end
    assign motor_c_gecerli = e_v[2] | spur;
    assign motor_sifre     = e_d2;

    // Engine model for the 8-bit DUT, 1-cycle latency.
    logic         e8_v = 1'b0;
    logic [127:0] e8_d = 128'h0;
    always @(posedge clk) begin
        e8_v <= motor_g_gecerli8;
        e8_d <= ks(motor_blok8);
    end
    assign motor_c_gecerli8 = e8_v;
    assign motor_sifre8     = e8_d;

    // Reference model: every accepted plaintext is owed one ciphertext, in order.
    logic [127:0] exp_ct_q [$];
    logic [95:0]  m_prefix = 96'h0;
    logic [31:0]  m_ctr    = 32'h0;
    bit           m_run    = 1'b0;

    // Advance one clock, recording handshakes and updating the model.
    task automatic tick(output bit iss, output logic [127:0] eblk, output bit pop,
                        output logic [127:0] gct, output logic [127:0] ect,
                        output bit erdy, output bit ordy);
        #1;
        ordy = a_hazir;
        erdy = m_run && motor_hazir && (exp_ct_q.size() < 16);
        iss  = a_gecerli && a_hazir;
        pop  = s_gecerli && s_hazir;
        gct  = sifreli_metin;
        eblk = 128'h0;
        ect  = 128'h0;
        if (iss) begin
            eblk = {m_prefix, m_ctr};
            exp_ct_q.push_back(acik_metin ^ ks(eblk));
            m_ctr = m_ctr + 32'd1;
        end
        if (pop) begin
            if (exp_ct_q.size() > 0) ect = exp_ct_q.pop_front();
            else ect = ~gct;
        end
        if (baslat) begin
            m_prefix = nonce[127:32];
            m_ctr    = 32'h0;
            m_run    = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; baslat = 1'b0; nonce = 128'h0; acik_metin = 128'h0;
        a_gecerli = 1'b1; motor_hazir = 1'b1; s_hazir = 1'b1;
        baslat8 = 1'b0; nonce8 = 128'h0; acik_metin8 = 128'h0;
        a_gecerli8 = 1'b0; motor_hazir8 = 1'b1; s_hazir8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({motor_blok, sifreli_metin} !== 256'h0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0", motor_blok, sifreli_metin); end
        n_chk++; if ({a_hazir, motor_g_gecerli, s_gecerli, tukendi} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {a_hazir, motor_g_gecerli, s_gecerli, tukendi}); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (a_hazir !== 1'b0) begin n_fail++; $display("FAIL bos_a_hazir: got %b want 0", a_hazir); end
        n_chk++; if (motor_g_gecerli !== 1'b0) begin n_fail++; $display("FAIL bos_no_issue: got %b want 0", motor_g_gecerli); end
        a_gecerli = 1'b0;
    endtask

    task automatic test_single();
        bit iss, pop, erdy, ordy, c_b, seen;
        logic [127:0] eblk, gct, ect;
        logic [127:0] pt  = 128'h71776572747975696F70617364666768;
        logic [127:0] blk = 128'h657870616E642033322D627900000000;
        s_hazir = 1'b0; motor_hazir = 1'b1;
        nonce = 128'h657870616E642033322D62797465206B; baslat = 1'b1;
        tick(iss, eblk, pop, gct, ect, erdy, ordy);
        baslat = 1'b0;
        a_gecerli = 1'b1; acik_metin = pt;
        tick(iss, eblk, pop, gct, ect, erdy, ordy);
        a_gecerli = 1'b0;
        n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL single_a_hazir: got %b want %b", ordy, erdy); end
        n_chk++; if (motor_g_gecerli !== 1'b1 || motor_blok !== blk) begin n_fail++; $display("FAIL single_blok: got %b %h want 1 %h", motor_g_gecerli, motor_blok, blk); end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            c_b = motor_c_gecerli;
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            seen = c_b;
            n_chk++; if (s_gecerli !== c_b) begin n_fail++; $display("FAIL single_latency: got %b want %b", s_gecerli, c_b); end
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL single_timeout: got no keystream want one"); end
        n_chk++; if (sifreli_metin !== (pt ^ ks(blk))) begin n_fail++; $display("FAIL single_ct: got %h want %h", sifreli_metin, pt ^ ks(blk)); end
        s_hazir = 1'b1;
        tick(iss, eblk, pop, gct, ect, erdy, ordy);
        n_chk++; if (!pop || gct !== ect) begin n_fail++; $display("FAIL single_pop: got %b %h want 1 %h", pop, gct, ect); end
        n_chk++; if (s_gecerli !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", s_gecerli); end
    endtask

    task automatic test_back_to_back();
        bit iss, pop, erdy, ordy;
        logic [127:0] eblk, gct, ect, nb;
        int npop = 0;
        nb = rnd128();
        s_hazir = 1'b1; motor_hazir = 1'b1; nonce = nb; baslat = 1'b1;
        tick(iss, eblk, pop, gct, ect, erdy, ordy);
        baslat = 1'b0;
        for (int i = 0; i < 60; i++) begin
            a_gecerli  = (i < 20);
            acik_metin = rnd128();
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            if (i < 20) begin
                n_chk++; if (motor_g_gecerli !== 1'b1 || motor_blok !== {nb[127:32], 32'(i)}) begin n_fail++; $display("FAIL b2b_counter: got %b %h want 1 %h", motor_g_gecerli, motor_blok, {nb[127:32], 32'(i)}); end
            end
            n_chk++; if (motor_g_gecerli !== iss) begin n_fail++; $display("FAIL b2b_g_gecerli: got %b want %b", motor_g_gecerli, iss); end
            if (pop) begin
                npop++;
                n_chk++; if (gct !== ect) begin n_fail++; $display("FAIL b2b_ct: got %h want %h", gct, ect); end
            end
            n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL b2b_a_hazir: got %b want %b", ordy, erdy); end
        end
        n_chk++; if (npop != 20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", npop); end
    endtask

    task automatic test_backpressure();
        bit iss, pop, erdy, ordy;
        logic [127:0] eblk, gct, ect;
        int nis = 0;
        s_hazir = 1'b0; motor_hazir = 1'b1; a_gecerli = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) s_hazir = 1'b1;
            if (i == 60) a_gecerli = 1'b0;
            acik_metin = rnd128();
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            if (i < 40 && iss) nis++;
            if (i == 39) begin
                n_chk++; if (nis != 16) begin n_fail++; $display("FAIL bp_issue_count: got %0d want 16", nis); end
                n_chk++; if (a_hazir !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b want 0", a_hazir); end
            end
            n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL bp_a_hazir: got %b want %b", ordy, erdy); end
            n_chk++; if (motor_g_gecerli !== iss) begin n_fail++; $display("FAIL bp_g_gecerli: got %b want %b", motor_g_gecerli, iss); end
            if (iss) begin n_chk++; if (motor_blok !== eblk) begin n_fail++; $display("FAIL bp_blok: got %h want %h", motor_blok, eblk); end end
            if (pop) begin n_chk++; if (gct !== ect) begin n_fail++; $display("FAIL bp_ct: got %h want %h", gct, ect); end end
        end
        n_chk++; if (exp_ct_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d owed want 0", exp_ct_q.size()); end
    endtask

    task automatic test_baslat_mid();
        bit iss, pop, erdy, ordy;
        logic [127:0] eblk, gct, ect, nb;
        nb = rnd128();
        s_hazir = 1'b1; motor_hazir = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_gecerli  = (i < 3);
            baslat     = (i == 1);
            if (i == 1) nonce = nb;
            acik_metin = rnd128();
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            if (i == 2) begin
                n_chk++; if (motor_blok !== {nb[127:32], 32'h0}) begin n_fail++; $display("FAIL mid_new_prefix: got %h want %h", motor_blok, {nb[127:32], 32'h0}); end
            end
            n_chk++; if (motor_g_gecerli !== iss) begin n_fail++; $display("FAIL mid_g_gecerli: got %b want %b", motor_g_gecerli, iss); end
            if (iss) begin n_chk++; if (motor_blok !== eblk) begin n_fail++; $display("FAIL mid_blok: got %h want %h", motor_blok, eblk); end end
            if (pop) begin n_chk++; if (gct !== ect) begin n_fail++; $display("FAIL mid_ct: got %h want %h", gct, ect); end end
            n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL mid_a_hazir: got %b want %b", ordy, erdy); end
        end
        baslat = 1'b0;
    endtask

    task automatic test_random();
        bit iss, pop, erdy, ordy;
        logic [127:0] eblk, gct, ect;
        for (int i = 0; i < 460; i++) begin
            if (i < 400) begin
                a_gecerli   = ($urandom_range(0, 9) < 7);
                s_hazir     = ($urandom_range(0, 9) < 6);
                motor_hazir = ($urandom_range(0, 9) < 8);
                baslat      = ($urandom_range(0, 99) < 2);
            end else begin
                a_gecerli = 1'b0; s_hazir = 1'b1; motor_hazir = 1'b1; baslat = 1'b0;
            end
            nonce      = rnd128();
            acik_metin = rnd128();
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL rnd_a_hazir: got %b want %b", ordy, erdy); end
            n_chk++; if (motor_g_gecerli !== iss) begin n_fail++; $display("FAIL rnd_g_gecerli: got %b want %b", motor_g_gecerli, iss); end
            if (iss) begin n_chk++; if (motor_blok !== eblk) begin n_fail++; $display("FAIL rnd_blok: got %h want %h", motor_blok, eblk); end end
            if (pop) begin n_chk++; if (gct !== ect) begin n_fail++; $display("FAIL rnd_ct: got %h want %h", gct, ect); end end
        end
        n_chk++; if (exp_ct_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d owed want 0", exp_ct_q.size()); end
    endtask

    task automatic test_protocol_error();
        a_gecerli = 1'b0; s_hazir = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (s_gecerli !== 1'b0) begin n_fail++; $display("FAIL proto_err: got %b want 0", s_gecerli); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_exhaust();
        logic [127:0] nb;
        logic [8:0]   cnt8 = 9'd0;
        nb = rnd128();
        nonce8 = nb; baslat8 = 1'b1;
        @(posedge clk); #1;
        baslat8 = 1'b0; a_gecerli8 = 1'b1;
        for (int i = 0; i < 320; i++) begin
            acik_metin8 = rnd128();
            @(posedge clk); #1;
            if (motor_g_gecerli8) begin
                n_chk++; if (motor_blok8 !== {nb[127:8], cnt8[7:0]}) begin n_fail++; $display("FAIL exh_blok: got %h want %h", motor_blok8, {nb[127:8], cnt8[7:0]}); end
                cnt8 = cnt8 + 9'd1;
            end
        end
        n_chk++; if (cnt8 != 9'd256) begin n_fail++; $display("FAIL exh_count: got %0d want 256", cnt8); end
        n_chk++; if (tukendi8 !== 1'b1 || a_hazir8 !== 1'b0) begin n_fail++; $display("FAIL exh_flags: got %b%b want 10", tukendi8, a_hazir8); end
        nb = rnd128();
        nonce8 = nb; baslat8 = 1'b1; a_gecerli8 = 1'b0;
        @(posedge clk); #1;
        baslat8 = 1'b0;
        n_chk++; if (tukendi8 !== 1'b0) begin n_fail++; $display("FAIL exh_clear: got %b want 0", tukendi8); end
        a_gecerli8 = 1'b1;
        @(posedge clk); #1;
        a_gecerli8 = 1'b0;
        n_chk++; if (motor_g_gecerli8 !== 1'b1 || motor_blok8 !== {nb[127:8], 8'h00}) begin n_fail++; $display("FAIL exh_restart: got %b %h want 1 %h", motor_g_gecerli8, motor_blok8, {nb[127:8], 8'h00}); end
    endtask

    task automatic test_reset_flight();
        bit iss, pop, erdy, ordy;
        logic [127:0] eblk, gct, ect;
        nonce = rnd128(); baslat = 1'b1; s_hazir = 1'b0; motor_hazir = 1'b1;
        tick(iss, eblk, pop, gct, ect, erdy, ordy);
        baslat = 1'b0;
        a_gecerli = 1'b1;
        repeat (5) begin
            acik_metin = rnd128();
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
        end
        a_gecerli = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_chk++; if ({motor_blok, sifreli_metin} !== 256'h0) begin n_fail++; $display("FAIL rstf_data: got %h %h want 0", motor_blok, sifreli_metin); end
        n_chk++; if ({a_hazir, motor_g_gecerli, s_gecerli, tukendi} !== 4'b0000) begin n_fail++; $display("FAIL rstf_ctrl: got %b want 0000", {a_hazir, motor_g_gecerli, s_gecerli, tukendi}); end
        exp_ct_q.delete();
        m_run = 1'b0; m_ctr = 32'h0; m_prefix = 96'h0;
        @(posedge clk); #1;
        rst = 1'b1; s_hazir = 1'b1; a_gecerli = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(iss, eblk, pop, gct, ect, erdy, ordy);
            n_chk++; if (s_gecerli !== 1'b0) begin n_fail++; $display("FAIL rstf_stale: got %b want 0", s_gecerli); end
            n_chk++; if (ordy !== erdy) begin n_fail++; $display("FAIL rstf_a_hazir: got %b want %b", ordy, erdy); end
            n_chk++; if (motor_g_gecerli !== iss) begin n_fail++; $display("FAIL rstf_g_gecerli: got %b want %b", motor_g_gecerli, iss); end
            if (pop) begin n_chk++; if (gct !== ect) begin n_fail++; $display("FAIL rstf_ct: got %h want %h", gct, ect); end end
        end
        a_gecerli = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_baslat_mid();
        test_random();
        test_protocol_error();
        test_exhaust();
        test_reset_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_ctr_kontrol.md
Name: aes_ctr_kontrol

Overview:
CTR-mode controller wrapped around aes_engine: feeds it counter blocks and consumes the keystream it produces.
- Accepts a plaintext stream on a valid/ready handshake.
- Forms nonce||counter input blocks for aes_engine and buffers plaintext while blocks are in flight.
- XORs each returned keystream word (sifre) with its paired plaintext.
- Presents ciphertext on a backpressurable output, credit-limited so aes_engine output, which has no backpressure, can never overflow.

Parameters:
- DERINLIK, 16: depth of the plaintext and ciphertext FIFOs; power of 2, minimum 4.
- SAYAC_W, 32: width of the counter field in the low bits of the block; 8..64.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- baslat  in  1  one-cycle pulse: load nonce and clear the counter.
- nonce  in  128  bits [127:SAYAC_W] form the fixed prefix; low bits are ignored.
- acik_metin  in  128  plaintext block.
- a_gecerli  in  1  plaintext valid.
- a_hazir  out  1  plaintext ready.
- motor_blok  out  128  counter block to aes_engine blok.
- motor_g_gecerli  out  1  to aes_engine g_gecerli.
- motor_hazir  in  1  from aes_engine hazir.
- motor_sifre  in  128  from aes_engine sifre (keystream).
- motor_c_gecerli  in  1  from aes_engine c_gecerli.
- sifreli_metin  out  128  ciphertext.
- s_gecerli  out  1  ciphertext valid.
- s_hazir  in  1  ciphertext ready.
- tukendi  out  1  counter exhausted; sticky until the next baslat.

Behaviour:
Reset (rst=0, asynchronous):
- State BOS; counter 0; prefix 0; both FIFOs empty; credit = DERINLIK.
- All outputs 0, including motor_blok and sifreli_metin.

States:
- BOS: a_hazir=0. baslat -> CALIS.
- CALIS: a_hazir = motor_hazir and credit>0. Transitions to TUKENDI on counter exhaustion (below).
- TUKENDI: a_hazir=0, tukendi=1. baslat -> CALIS and tukendi clears.

Issue (a_gecerli and a_hazir in the same cycle):
- Registered outputs: motor_blok = {prefix, counter} and motor_g_gecerli=1 on the next cycle.
- acik_metin is pushed into the plaintext FIFO; counter increments; credit decrements.
- motor_g_gecerli=0 in every cycle without an issue.
- Throughput: one block per cycle.

Counter exhaustion:
- Issuing counter value all-ones moves the state to TUKENDI on the next cycle.
- The counter never wraps; no block with counter 0 is ever reissued under the same prefix.

Keystream return:
- On motor_c_gecerli: pop the plaintext FIFO head, XOR with motor_sifre, push the result into the ciphertext FIFO in the same cycle.
- Blocks return in issue order (aes_engine is an in-order pipeline).

Output:
- s_gecerli = ciphertext FIFO not empty; sifreli_metin = FIFO head.
- A pop occurs when s_gecerli and s_hazir; it increments credit.

Credit rules:
- credit = DERINLIK - (in_flight + ciphertext_occupancy); width $clog2(DERINLIK)+1.
- Issue and pop in the same cycle leave credit unchanged.
- Credit is never negative, and the ciphertext FIFO never receives a push while full.

Error conditions:
- motor_c_gecerli while the plaintext FIFO is empty is a protocol error: the beat is ignored and no push occurs.

baslat during CALIS:
- Reloads prefix and counter for subsequent issues.
- In-flight blocks complete with their original pairing.
- baslat and an issue in the same cycle: the issue uses the old {prefix, counter}; the reload applies afterwards.

Latency:
- Issue -> motor_g_gecerli: 1 cycle.
- motor_c_gecerli -> s_gecerli: 1 cycle.

Optional Feature:
AES_CTR_ISTATISTIK_EN
- Defined: adds output blok_sayisi [31:0], counting output pops. Reset to 0 and cleared on baslat; saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package aes_pkg: BLOK_W=128 and the block typedef.
- One sub-module, aes_fifo (DERINLIK, width 128; push/pop/full/empty), instantiated twice: plaintext and ciphertext.

Test Plan:
- Reset, baslat with nonce=0x657870616E642033322D62797465206B, single block acik_metin=0x71776572747975696F70617364666768 -> motor_blok = prefix||0x00000001? No: low 32 bits = 0x00000000; sifreli_metin = acik_metin XOR returned sifre.
- Back-to-back 20 blocks, s_hazir=1 -> motor_blok counter field 0..19 on consecutive cycles; 20 outputs in order.
- s_hazir=0 with continuous input -> exactly DERINLIK (16) issues, then a_hazir=0. Raising s_hazir resumes issue one block per pop.
- SAYAC_W=8, counter preset by issuing 255 blocks -> 256th issue uses 0xFF, then tukendi=1 and a_hazir=0. baslat clears tukendi and the next issue uses counter 0x00.
- rst asserted with 5 blocks in flight -> all outputs 0 immediately; after release state is BOS and no stale s_gecerli appears when the engine returns old beats.
- baslat in the same cycle as an issue -> that block carries the old prefix, the next block carries the new prefix with counter 0.
